// File: rtl/display_scan_7seg.sv
// display_scan_7seg: multiplexed 7-segment scanner with frame-synchronous capture, per-digit blink and ghost blanking
module display_scan_7seg #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int BLINK_DIV   = 64,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] disp_word,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_start
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(BLINK_DIV) + 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    phase_q, phase_d;
  logic                    dis_q, dis_d;
  logic [4*NUM_DIGITS-1:0] sw_q, sw_d;
  logic [NUM_DIGITS-1:0]   sm_q, sm_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fs_q, fs_d;
  logic                    tick, fs, fwrap;
  logic [3:0]              nib;
  // dis_q remembers a disabled cycle so the first enabled cycle after it opens a fresh frame
  always_comb begin
    tick    = pre_q == PW'(SCAN_DIV - 1);
    fs      = enable && ((tick && idx_q == IW'(NUM_DIGITS - 1)) || dis_q);
    fwrap   = fcnt_q == FW'(BLINK_DIV - 1);
    pre_d   = (!enable || tick) ? '0 : pre_q + 1'b1;
    idx_d   = !enable ? '0 : !tick ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    fcnt_d  = !enable ? '0 : !fs ? fcnt_q : fwrap ? '0 : fcnt_q + 1'b1;
    phase_d = enable && (fs && fwrap ? !phase_q : phase_q);
    dis_d   = !enable;
    sw_d    = (!enable || fs) ? disp_word : sw_q;
    sm_d    = (!enable || fs) ? blink_mask : sm_q;
    nib     = 4'(sw_q >> {idx_q, 2'b00});
    seg_d   = (enable && !(phase_q && sm_q[idx_q])) ? SEG_LUT[nib] : 7'h00;
    dig_d   = (enable && pre_q >= PW'(BLANK_CYC)) ? NUM_DIGITS'(1) << idx_q : '0;
    fs_d    = fs;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      dis_q   <= 1'b0;
      sw_q    <= '0;
      sm_q    <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      dis_q   <= dis_d;
      sw_q    <= sw_d;
      sm_q    <= sm_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fs_q    <= fs_d;
    end
  end
  assign seg         = seg_q ^ {7{SEG_ACT_LOW}};
  assign dig         = dig_q ^ {NUM_DIGITS{DIG_ACT_LOW}};
  assign frame_start = fs_q;
endmodule
